instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: holds the program counter, issues one read to
// instruction memory per PC value and keeps the returned word registered
// for the decode stage. A wait counter flags memory that never answers.
//
// state | meaning
// ------+----------------------------------------------------------------
// FETCH | imem_req high at address PC, waiting for imem_ack
// HOLD  | instruction valid for PC; waiting for PCWre to select a new PC
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [7:0]  WAIT_LIMIT = 8'd255
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] immediate,
  input  logic [25:0] addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        inst_valid,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        fetch_err
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] next_raw;
  logic [31:0] next_pc;
  logic [8:0]  wait_sum;

  // Next-PC selection; all sums wrap modulo 2^32 and the result is word aligned.
  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    branch_off = {{14{immediate[15]}}, immediate, 2'b00};
    next_raw   = pc_plus4;
    case (PCSrc)
      2'b00:   next_raw = pc_plus4;
      2'b01:   next_raw = pc_plus4 + branch_off;
      2'b10:   next_raw = {pc_plus4[31:28], addr, 2'b00};
      default: next_raw = pc_q;
    endcase
    next_pc = next_raw & 32'hFFFF_FFFC;
  end

  // FSM next-state and datapath update. The request flop is low straight
  // out of reset, so an ack that arrives before the first request is never
  // taken as a response; the wait counter only runs while a request is out.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    err_d      = err_q;
    req_d      = req_q;
    wait_cnt_d = wait_cnt_q;
    wait_sum   = {1'b0, wait_cnt_q} + 9'd1;

    case (state_q)
      ST_FETCH: begin
        if (req_q) begin
          // This cycle counts toward the limit even if ack arrives in it.
          if (wait_sum >= {1'b0, WAIT_LIMIT}) begin
            err_d = 1'b1;
          end
          if (imem_ack) begin
            instr_d    = imem_rdata;
            valid_d    = 1'b1;
            req_d      = 1'b0;
            wait_cnt_d = 8'd0;
            state_d    = ST_HOLD;
          end else if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          req_d      = 1'b1;
          wait_cnt_d = 8'd0;
        end
      end

      ST_HOLD: begin
        req_d      = 1'b0;
        wait_cnt_d = 8'd0;
        if (PCWre && (PCSrc != 2'b11)) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d    = ST_FETCH;
        req_d      = 1'b0;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // State and output registers; reset forces the idle values without a clock.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      req_q      <= req_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign inst_valid  = valid_q;
  assign PC          = pc_q;
  assign PC4         = pc_plus4;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a memory responder with chosen
// latencies, a transaction-level PC model feeding an expected-fetch queue,
// and a monitor that checks every cycle against that queue.
`timescale 1ns/1ps
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          WAIT_LIMIT = 255;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [15:0] immediate;
  logic [25:0] addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        inst_valid;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        fetch_err;

  always #5 CLK = ~CLK;

  instruction_fetch #(.RESET_PC(RESET_PC), .WAIT_LIMIT(8'd255)) dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
    .immediate(immediate), .addr(addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .inst_valid(inst_valid), .PC(PC),
    .PC4(PC4), .fetch_err(fetch_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_t;

  typedef struct {
    logic        we;
    logic [1:0]  src;
    logic [15:0] imm;
    logic [25:0] adr;
  } cmd_t;

  fetch_t      exp_q[$];
  cmd_t        dir_q[$];
  int          lat_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  logic        mon_en   = 1'b0;
  logic        stale    = 1'b0;
  logic        err_exp  = 1'b0;
  logic [31:0] model_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2001_0005;
  endfunction

  // Reference next-PC: plain arithmetic on the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input cmd_t c);
    logic [31:0] seq;
    logic [31:0] off;
    logic [31:0] tgt;
    seq = pc + 32'd4;
    off = {{16{c.imm[15]}}, c.imm};
    tgt = {6'b0, c.adr};
    case (c.src)
      2'd0:    return seq & ~32'd3;
      2'd1:    return (seq + off * 32'd4) & ~32'd3;
      default: return ((seq & 32'hF000_0000) | (tgt * 32'd4)) & ~32'd3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic [1:0] src,
                              input logic [15:0] imm, input logic [25:0] adr);
    cmd_t c;
    c.we = we; c.src = src; c.imm = imm; c.adr = adr;
    return c;
  endfunction

  task automatic push_exp(input logic [31:0] a);
    fetch_t f;
    f.addr = a;
    f.data = mem_word(a);
    exp_q.push_back(f);
  endtask

  // One clock of stimulus; control is only meaningful while the DUT holds.
  task automatic step();
    cmd_t c;
    @(posedge CLK); #1;
    if (inst_valid) begin
      if (dir_q.size() > 0) begin
        c = dir_q.pop_front();
      end else begin
        c.we  = ($urandom % 4) != 0;
        c.src = 2'($urandom_range(0, 3));
        c.imm = 16'($urandom);
        c.adr = 26'($urandom);
      end
      PCWre = c.we; PCSrc = c.src; immediate = c.imm; addr = c.adr;
      if (c.we && c.src != 2'b11) begin
        model_pc = model_next(model_pc, c);
        push_exp(model_pc);
      end
    end else begin
      PCWre = 1'($urandom); PCSrc = 2'($urandom);
      immediate = 16'($urandom); addr = 26'($urandom);
    end
  endtask

  // Reset asserted between edges; outputs must settle without a clock.
  task automatic apply_reset();
    @(posedge CLK); #2;
    Reset  = 1'b0;
    mon_en = 1'b0;
    #1;
    check("rst_pc", PC, RESET_PC);
    check("rst_instr", instruction, 32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_err", {31'b0, fetch_err}, 32'd0);
    exp_q.delete();
    dir_q.delete();
    repeat (3) @(posedge CLK);
    stale = 1'b1;
    @(negedge CLK);
    Reset    = 1'b1;
    model_pc = RESET_PC;
    push_exp(model_pc);
    step();
    stale  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Memory responder: acks after a chosen number of wait cycles and keeps
  // the expected timeout flag from its own count of requesting cycles.
  initial begin : responder
    int lat;
    int req_cycles;
    logic err_pend;
    lat = 0; req_cycles = 0; err_pend = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(posedge CLK); #1;
      if (!Reset) begin
        req_cycles = 0;
        err_pend   = 1'b0;
        err_exp    = 1'b0;
        imem_ack   = stale;
        imem_rdata = stale ? 32'hDEAD_BEEF : $urandom;
      end else begin
        if (err_pend) begin
          err_exp  = 1'b1;
          err_pend = 1'b0;
        end
        if (imem_req) begin
          if (req_cycles == 0) lat = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom % 4);
          req_cycles++;
          if (req_cycles >= WAIT_LIMIT) err_pend = 1'b1;
          if (req_cycles > lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            req_cycles = 0;
          end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
          end
        end else begin
          imem_ack   = 1'($urandom);
          imem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the expected-fetch queue.
  initial begin : monitor
    fetch_t cur;
    logic   prev_valid;
    prev_valid = 1'b0;
    cur.addr = 32'h0; cur.data = 32'h0;
    forever begin
      @(negedge CLK);
      if (mon_en && Reset) begin
        if (!inst_valid) begin
          check("req_in_fetch", {31'b0, imem_req}, 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
          end else begin
            check("fetch_addr", imem_addr, exp_q[0].addr);
            check("pc_fetch", PC, exp_q[0].addr);
            check("pc4_fetch", PC4, exp_q[0].addr + 32'd4);
          end
        end else begin
          check("req_in_hold", {31'b0, imem_req}, 32'd0);
          if (!prev_valid) begin
            if (exp_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL fetch_done_unexpected: got pc %h expected no completion", PC);
            end else begin
              cur = exp_q.pop_front();
              n_pops++;
            end
          end
          check("pc_hold", PC, cur.addr);
          check("instr", instruction, cur.data);
          check("pc4_hold", PC4, cur.addr + 32'd4);
        end
        check("fetch_err", {31'b0, fetch_err}, {31'b0, err_exp});
      end
      prev_valid = inst_valid;
    end
  end

  initial begin : main
    logic found;
    Reset = 1'b0; PCWre = 1'b0; PCSrc = 2'b00; immediate = 16'h0; addr = 26'h0;
    lat_q = '{0, 0, 3, 1, 253, 0, 254, 2, 300, 0};
    apply_reset();

    dir_q.push_back(mk(1'b1, 2'b10, 16'h0000, 26'h000_0004));   // -> 0x10
    dir_q.push_back(mk(1'b1, 2'b01, 16'hFFFE, 26'h0));          // -> 0x0C
    repeat (5) dir_q.push_back(mk(1'b0, 2'b00, 16'h1234, 26'h0));
    repeat (3) dir_q.push_back(mk(1'b1, 2'b11, 16'h0004, 26'h0));
    dir_q.push_back(mk(1'b1, 2'b10, 16'h0000, 26'h000_0000));   // -> 0x00
    dir_q.push_back(mk(1'b1, 2'b01, 16'hFFFE, 26'h0));          // -> 0xFFFFFFFC
    dir_q.push_back(mk(1'b1, 2'b00, 16'h0000, 26'h0));          // wraps to 0
    dir_q.push_back(mk(1'b1, 2'b01, 16'h8000, 26'h0));          // -> 0xFFFE0004
    dir_q.push_back(mk(1'b1, 2'b10, 16'h0000, 26'h000_0040));   // -> 0xF0000100

    repeat (1500) step();
    check("lat_q_drained", lat_q.size(), 32'd0);
    check("sticky_err", {31'b0, fetch_err}, 32'd1);

    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (inst_valid) found = 1'b1; else step();
    end
    check("wait_first_hold", {31'b0, found}, 32'd1);
    lat_q.push_back(40);
    dir_q.push_back(mk(1'b1, 2'b10, 16'h0000, 26'h000_0008));   // -> 0x20
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 32'h20) found = 1'b1;
    end
    check("wait_fetch_20", {31'b0, found}, 32'd1);
    repeat (5) step();
    check("mid_fetch_pc", PC, 32'h20);
    check("mid_fetch_req", {31'b0, imem_req}, 32'd1);
    apply_reset();
    repeat (80) step();
    check("fetch_count", {31'b0, n_pops > 30}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
